multicycle_ctrl: RTL and testbench

- Control sequencer for the multicycle RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Issues the instruction-memory and data-memory request/acknowledge handshakes, and generates the write enables for PC, IR and the register file.
- Consumes the decoder's classification flags, so the rest of the core remains a pure datapath.

---
 rtl/multicycle_ctrl.sv | 112 +++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control sequencer: F/D/E/M/W stepping with memory handshakes and PC/IR/RF strobes.
// Strobes are combinational on state + same-cycle inputs; optional perf counters under MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_halt,
    input  logic        reg_we,
    input  logic        br_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [31:0] pc_init,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:   if (imem_ack) cur <= DECODE;
                DECODE:  cur <= is_halt ? HALT : EXEC;
                EXEC:    cur <= (is_load | is_store) ? MEM : WB;
                // load+store together resolves as a store
                MEM:     if (dmem_ack) cur <= is_store ? FETCH : WB;
                WB:      cur <= FETCH;
                HALT:    cur <= HALT;
                default: cur <= FETCH;
            endcase
        end
    end

    // Reset masks every strobe so an in-flight access cannot emit a write pulse.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        if (!rst) begin
            case (cur)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    pc_we    = dmem_ack & is_store;
                end
                WB: begin
                    rf_we  = reg_we;
                    pc_we  = 1'b1;
                    pc_sel = br_taken;
                end
                default: ;
            endcase
        end
    end

    assign state   = cur;
    assign halted  = (cur == HALT);
    assign pc_init = RESET_PC;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (cur != HALT) cycle_q <= cycle_q + 32'd1;
            if (pc_we)       instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, then randomized instruction traces from a per-instruction cycle model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0, reg_we = 1'b0, br_taken = 1'b0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, halted;
    logic [31:0] pc_init, cycle_cnt, instret_cnt;
    logic [2:0]  state;

    multicycle_ctrl #(.RESET_PC(32'h0000_1000)) dut (
        .clk(clk), .rst(rst),
        .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
        .reg_we(reg_we), .br_taken(br_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .pc_init(pc_init), .state(state), .halted(halted),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [7:0] IREQ = 8'h80, DREQ = 8'h40, DWE = 8'h20, IRWE = 8'h10;
    localparam logic [7:0] RFWE = 8'h08, PCWE = 8'h04, PCSEL = 8'h02, HLT = 8'h01;

    typedef struct {
        logic       rst, iack, dack, ld, st, hl, rwe, br;
        logic [2:0] s;
        logic [7:0] o;
    } vec_t;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] exp_cyc = 0;
    logic [31:0] exp_ret = 0;
    vec_t        tbl[$];
    vec_t        q[$];

    function automatic vec_t mk(input logic r, ia, da, ld, st, hl, rwe, br,
                                input logic [2:0] s, input logic [7:0] o);
        vec_t v;
        v.rst = r; v.iack = ia; v.dack = da; v.ld = ld; v.st = st;
        v.hl = hl; v.rwe = rwe; v.br = br; v.s = s; v.o = o;
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the counter model past the next edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; imem_ack = v.iack; dmem_ack = v.dack;
        is_load = v.ld; is_store = v.st; is_halt = v.hl; reg_we = v.rwe; br_taken = v.br;
        #1;
        chk(tag, {21'd0, state, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, halted},
            {21'd0, v.s, v.o});
        chk({tag, "/cyc"}, cycle_cnt, exp_cyc);
        chk({tag, "/ret"}, instret_cnt, exp_ret);
        if (PERF) begin
            if (v.rst) begin
                exp_cyc = 0;
                exp_ret = 0;
            end else begin
                if (v.s != 3'd5) exp_cyc = exp_cyc + 32'd1;
                if ((v.o & PCWE) != 8'd0) exp_ret = exp_ret + 32'd1;
            end
        end
    endtask

    // Expected cycle trace of one instruction, built from the phase latencies.
    task automatic gen_instr(input int kind, input int wi, input int wd);
        logic ld, st, hl, rwe, br;
        ld = 1'b0; st = 1'b0; hl = 1'b0; rwe = rb(); br = rb();
        if (kind == 1) ld = 1'b1;
        if (kind == 2) begin st = 1'b1; ld = rb(); end
        if (kind == 3) begin hl = 1'b1; ld = rb(); st = rb(); end
        for (int i = 0; i < wi; i++) q.push_back(mk(0, 0, rb(), rb(), rb(), rb(), rb(), rb(), 3'd0, IREQ));
        q.push_back(mk(0, 1, rb(), rb(), rb(), rb(), rb(), rb(), 3'd0, IREQ | IRWE));
        q.push_back(mk(0, rb(), rb(), ld, st, hl, rwe, br, 3'd1, 8'd0));
        if (hl) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                q.push_back(mk(0, rb(), rb(), ld, st, hl, rwe, br, 3'd5, HLT));
            q.push_back(mk(1, rb(), rb(), ld, st, hl, rwe, br, 3'd5, HLT));
            return;
        end
        q.push_back(mk(0, rb(), rb(), ld, st, hl, rwe, br, 3'd2, 8'd0));
        if (ld || st) begin
            for (int i = 0; i < wd; i++)
                q.push_back(mk(0, rb(), 0, ld, st, hl, rwe, br, 3'd3, DREQ | (st ? DWE : 8'd0)));
            q.push_back(mk(0, rb(), 1, ld, st, hl, rwe, br, 3'd3, DREQ | (st ? (DWE | PCWE) : 8'd0)));
            if (st) return;
        end
        q.push_back(mk(0, rb(), rb(), ld, st, hl, rwe, br, 3'd4,
                       (rwe ? RFWE : 8'd0) | PCWE | (br ? PCSEL : 8'd0)));
    endtask

    initial begin
        //                r ia da ld st hl rwe br  state expected outputs
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0));
        // ALU, reg_we=1, zero wait
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 3'd0, IREQ | IRWE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd1, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd2, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd4, RFWE | PCWE));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd0, IREQ));
        // taken branch, stray acks in EXEC
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 3'd0, IREQ | IRWE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 8'd0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 3'd2, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd4, PCWE | PCSEL));
        // store with reg_we=1
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, IREQ | IRWE));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3'd1, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3'd2, 8'd0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 3'd3, DREQ | DWE | PCWE));
        // load and store both set
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, IREQ | IRWE));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 3'd1, 8'd0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 3'd2, 8'd0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1, 0, 3'd3, DREQ | DWE | PCWE));
        // load, dmem_ack three cycles late
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, IREQ | IRWE));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 3'd1, 8'd0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 3'd2, 8'd0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 3'd3, DREQ));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'd3, DREQ));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 3'd3, DREQ));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 3'd3, DREQ));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 3'd4, RFWE | PCWE));
        // reset while dmem_req is high
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, IREQ | IRWE));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3'd1, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3'd2, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3'd3, DREQ | DWE));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 3'd3, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, IREQ));
        // halt, acks ignored, released by reset
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, IREQ | IRWE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 3'd1, 8'd0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 3'd5, HLT));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 3'd5, HLT));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 3'd5, HLT));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, IREQ));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        chk("pc_init", pc_init, 32'h0000_1000);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 200; n++) begin
            int k;
            int wi;
            int wd;
            k  = int'($urandom_range(0, 9));
            wi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            gen_instr((k < 5) ? 0 : (k < 7) ? 1 : (k < 9) ? 2 : 3, wi, wd);
        end
        for (int i = 0; i < q.size(); i++) apply(q[i], $sformatf("rnd%0d", i));

        // ten ALU instructions straight out of reset
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0), "ten_rst");
        for (int n = 0; n < 10; n++) begin
            apply(mk(0, 1, 0, 0, 0, 0, 1, 0, 3'd0, IREQ | IRWE), $sformatf("ten%0d_f", n));
            apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd1, 8'd0), $sformatf("ten%0d_d", n));
            apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd2, 8'd0), $sformatf("ten%0d_e", n));
            apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd4, RFWE | PCWE), $sformatf("ten%0d_w", n));
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, IREQ), "ten_end");
        chk("cycle_cnt_40", cycle_cnt, PERF ? 32'd40 : 32'd0);
        chk("instret_cnt_10", instret_cnt, PERF ? 32'd10 : 32'd0);

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
        // preload both counters to all-ones just before a counted FETCH edge
        force dut.cycle_q   = 32'hFFFF_FFFF;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        release dut.instret_q;
        exp_cyc = 32'd0;
        exp_ret = 32'hFFFF_FFFF;
`endif
        apply(mk(0, 1, 0, 0, 0, 0, 1, 0, 3'd0, IREQ | IRWE), "wrap_f");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd1, 8'd0), "wrap_d");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd2, 8'd0), "wrap_e");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd4, RFWE | PCWE), "wrap_w");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, IREQ), "wrap_end");
        chk("instret_wrap", instret_cnt, 32'd0);
        chk("cycle_after_wrap", cycle_cnt, PERF ? 32'd4 : 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
